// File: rtl/srlatch_pkg.sv
// Shared state encoding and output decode for the clocked SR storage element.
// Outputs are packed as {q, q_bar}.
package srlatch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t Q0     = 2'b00;
    localparam state_t Q1     = 2'b01;
    localparam state_t FORBID = 2'b10;

    localparam logic [1:0] OUT_Q0     = 2'b01;
    localparam logic [1:0] OUT_Q1     = 2'b10;
    localparam logic [1:0] OUT_FORBID = 2'b00;

    // The unused encoding 2'b11 decodes like Q0, so it is always a safe value.
    function automatic logic [1:0] decode_out(input state_t st);
        logic [1:0] o;
        o = OUT_Q0;
        case (st)
            Q0:      o = OUT_Q0;
            Q1:      o = OUT_Q1;
            FORBID:  o = OUT_FORBID;
            default: o = OUT_Q0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/srlatch_next.sv
// Combinational next-state function of the SR storage element.
// Handles the FORBID exits and the recovery from the unused encoding.
module srlatch_next
    import srlatch_pkg::*;
(
    input  logic [1:0] state,
    input  logic       s,
    input  logic       r,
    output logic [1:0] next_state
);

    always_comb begin
        next_state = Q0;
        case ({s, r})
            2'b11: next_state = FORBID;
            2'b10: next_state = Q1;
            2'b01: next_state = Q0;
            default: begin
                // With no request, Q0 and Q1 hold; FORBID and the unused
                // encoding both resolve to Q0 (reset-dominant).
                if (state == Q1)
                    next_state = Q1;
                else
                    next_state = Q0;
            end
        endcase
    end

endmodule

// File: rtl/srlatch.sv
// Clocked set/reset storage element with complementary outputs.
// The state register resets asynchronously to Q0; outputs decode the register only.
module srlatch
    import srlatch_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic r,
    input  logic s,
    output logic q,
    output logic q_bar
);

    logic [1:0] state;
    logic [1:0] next_state;
    logic [1:0] out_bits;

    srlatch_next u_next (
        .state      (state),
        .s          (s),
        .r          (r),
        .next_state (next_state)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= Q0;
        else
            state <= next_state;
    end

    always_comb begin
        out_bits = decode_out(state);
    end

    assign q     = out_bits[1];
    assign q_bar = out_bits[0];

endmodule

// File: tb/tb_srlatch.sv
// Self-checking bench for srlatch: table vectors, corner sequences and a
// randomized run compared against an output-level behavioural model.
module tb_srlatch;

    logic clk;
    logic reset_n;
    logic r;
    logic s;
    logic q;
    logic q_bar;

    int tests;
    int fails;

    // Behavioural model held directly as the two output bits.
    logic mq;
    logic mqb;

    typedef struct {
        logic r;
        logic s;
        logic exp_q;
        logic exp_qb;
    } vec_t;

    vec_t vecs[6];

    srlatch dut (
        .clk     (clk),
        .reset_n (reset_n),
        .r       (r),
        .s       (s),
        .q       (q),
        .q_bar   (q_bar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic eq, input logic eqb);
        tests++;
        if (q !== eq || q_bar !== eqb) begin
            fails++;
            $display("FAIL %s at %0t: got q=%b q_bar=%b, expected q=%b q_bar=%b",
                     nm, $time, q, q_bar, eq, eqb);
        end
    endtask

    // Output-level rules: both high -> both low; set -> 1/0; reset -> 0/1;
    // idle holds a valid pair and turns the both-low pair into 0/1.
    task automatic model_update(input logic sv, input logic rv, input logic rst_lo);
        if (rst_lo) begin
            mq = 1'b0; mqb = 1'b1;
        end else if (sv && rv) begin
            mq = 1'b0; mqb = 1'b0;
        end else if (sv) begin
            mq = 1'b1; mqb = 1'b0;
        end else if (rv) begin
            mq = 1'b0; mqb = 1'b1;
        end else if (!mq && !mqb) begin
            mqb = 1'b1;
        end
    endtask

    // Drive at the falling edge, let one rising edge act, sample 1 ns later.
    task automatic clk_in(input logic sv, input logic rv, input logic rst_lo);
        @(negedge clk);
        s = sv;
        r = rv;
        reset_n = ~rst_lo;
        @(posedge clk);
        #1;
        model_update(sv, rv, rst_lo);
    endtask

    task automatic step(input string nm, input logic sv, input logic rv);
        clk_in(sv, rv, 1'b0);
        check(nm, mq, mqb);
    endtask

    task automatic do_reset();
        clk_in(1'b0, 1'b0, 1'b1);
        check("reset_pulse", 1'b0, 1'b1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        s = 1'b1;
        r = 1'b0;
        reset_n = 1'b1;
        mq = 1'b0;
        mqb = 1'b1;

        vecs[0] = '{r: 1'b0, s: 1'b0, exp_q: 1'b0, exp_qb: 1'b1};
        vecs[1] = '{r: 1'b1, s: 1'b0, exp_q: 1'b0, exp_qb: 1'b1};
        vecs[2] = '{r: 1'b0, s: 1'b1, exp_q: 1'b1, exp_qb: 1'b0};
        vecs[3] = '{r: 1'b1, s: 1'b1, exp_q: 1'b0, exp_qb: 1'b0};
        vecs[4] = '{r: 1'b1, s: 1'b0, exp_q: 1'b0, exp_qb: 1'b1};
        vecs[5] = '{r: 1'b0, s: 1'b0, exp_q: 1'b0, exp_qb: 1'b1};

        // Reset with a set request pending and the clock running.
        #1;
        reset_n = 1'b0;
        #1;
        check("reset_immediate", 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_held", 1'b0, 1'b1);
        end
        mq = 1'b0; mqb = 1'b1;
        step("reset_release_set", 1'b1, 1'b0);
        check("reset_release_q1", 1'b1, 1'b0);

        // Basic table sequence from Q0.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            clk_in(vecs[i].s, vecs[i].r, 1'b0);
            check($sformatf("table_%0d", i), vecs[i].exp_q, vecs[i].exp_qb);
        end

        // Hold after set.
        step("hold_set", 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            clk_in(1'b0, 1'b0, 1'b0);
            check("hold_after_set", 1'b1, 1'b0);
        end

        // FORBID exits.
        clk_in(1'b1, 1'b1, 1'b0);
        check("forbid_enter", 1'b0, 1'b0);
        clk_in(1'b0, 1'b0, 1'b0);
        check("forbid_exit_00", 1'b0, 1'b1);
        clk_in(1'b1, 1'b1, 1'b0);
        check("forbid_enter2", 1'b0, 1'b0);
        clk_in(1'b1, 1'b0, 1'b0);
        check("forbid_exit_set", 1'b1, 1'b0);
        clk_in(1'b1, 1'b1, 1'b0);
        check("forbid_enter3", 1'b0, 1'b0);
        clk_in(1'b0, 1'b1, 1'b0);
        check("forbid_exit_rst", 1'b0, 1'b1);

        // Latency: requests changed mid-cycle must not reach the outputs early.
        @(negedge clk);
        s = 1'b1; r = 1'b0;
        #1;
        check("latency_no_comb_set", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("latency_set_edge", 1'b1, 1'b0);
        #2;
        s = 1'b0; r = 1'b1;
        #1;
        check("latency_no_comb_rst", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("latency_rst_edge", 1'b0, 1'b1);
        mq = 1'b0; mqb = 1'b1;

        // Asynchronous reset pulse while in FORBID, between clock edges.
        clk_in(1'b1, 1'b1, 1'b0);
        check("async_forbid", 1'b0, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_pulse_low", 1'b0, 1'b1);
        #1;
        reset_n = 1'b1;
        #1;
        check("async_after_pulse", 1'b0, 1'b1);
        mq = 1'b0; mqb = 1'b1;
        step("async_then_hold", 1'b0, 1'b0);

        // Randomized run with occasional synchronous-looking reset cycles.
        for (int i = 0; i < 300; i++) begin
            logic sv;
            logic rv;
            logic rl;
            sv = 1'($urandom_range(0, 1));
            rv = 1'($urandom_range(0, 1));
            rl = ($urandom_range(0, 19) == 0);
            clk_in(sv, rv, rl);
            check("random", mq, mqb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
